// File: rtl/sha256_pkg.sv
// Shared types and helpers for the double-SHA256 datapath.
// Digest/target handling reuses bswap256 for byte-order conversion.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        REPORT
    } state_t;

    // Digest bytes are stored big-endian per word; the numeric value
    // reverses the whole 32-byte string.
    function automatic logic [255:0] bswap256(input logic [255:0] d);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = d[255-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/word_cmp32.sv
// Combinational 32-bit unsigned magnitude compare.
// Exactly one of lt/eq/gt is high.
module word_cmp32
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              lt,
    output logic              eq,
    output logic              gt
);

    assign lt = a < b;
    assign eq = a == b;
    assign gt = a > b;

endmodule

// File: rtl/digest_target_check.sv
// Checks a latched digest against a difficulty target, one word
// per cycle from the top word down, with early termination.
module digest_target_check
    import sha256_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [255:0]     digest_in,
    input  logic [31:0]      nonce_in,
    input  logic [255:0]     target_in,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             hit,
    output logic [31:0]      hit_nonce,
    output logic [CNT_W-1:0] hit_count
);

    state_t             state_q, state_d;
    logic [2:0]         k_q, k_d;
    logic [255:0]       v_q;
    logic [255:0]       t_q;
    logic [31:0]        nonce_q;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load;

    logic [WORD_W-1:0]  v_word;
    logic [WORD_W-1:0]  t_word;
    logic               w_lt, w_eq, w_gt;

    assign v_word = v_q[{k_q, 5'd0} +: WORD_W];
    assign t_word = t_q[{k_q, 5'd0} +: WORD_W];

    word_cmp32 u_cmp (
        .a  (v_word),
        .b  (t_word),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    k_d     = 3'(NUM_WORDS - 1);
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                unique case (1'b1)
                    w_lt: begin
                        hit_d   = 1'b1;
                        state_d = REPORT;
                    end
                    w_gt: begin
                        hit_d   = 1'b0;
                        state_d = REPORT;
                    end
                    (w_eq && k_q == 3'd0): begin
                        hit_d   = 1'b1;
                        state_d = REPORT;
                    end
                    default: begin
                        k_d = k_q - 3'd1;
                    end
                endcase
            end
            REPORT: begin
                if (result_ready) begin
                    if (hit_q && cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            k_q     <= 3'(NUM_WORDS - 1);
            v_q     <= '0;
            t_q     <= '0;
            nonce_q <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            if (load) begin
                v_q     <= bswap256(digest_in);
                t_q     <= target_in;
                nonce_q <= nonce_in;
            end
        end
    end

    assign busy         = state_q != IDLE;
    assign result_valid = state_q == REPORT;
    assign hit          = hit_q;
    assign hit_nonce    = nonce_q;
    assign hit_count    = cnt_q;

endmodule
